sram_ctrl_1rw1r: RTL

- Initiator-side controller for the 32x256 1RW+1R OpenRAM macro (byte write mask).
- Converts two valid/ready request streams into the macro's pin protocol: port A read/write, port B read-only.
- Captures macro read data in the one cycle it is valid.
- Zero-fills the array after reset, and arbitrates same-cycle write/read address collisions.

---
 rtl/sram_ctrl_pkg.sv | 12 +
 rtl/sram_rsp_slot.sv | 76 +++++++
 rtl/sram_ctrl_1rw1r.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the 1RW+1R SRAM controller: controller state encoding
// and the geometry of the 32x256 byte-masked OpenRAM macro.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 8;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_NWMASK = 4;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/sram_rsp_slot.sv
// Response register for one controller port.
// Holds captured macro data until the consumer accepts it, and reports
// whether a new request may be accepted.
module sram_rsp_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_en_i,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  input  logic                  rsp_ready_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  req_ok_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  // A request may be accepted while the previous one is still in flight.
  // If its consumer then stalls, the second capture parks here rather than
  // overwriting unacknowledged data.
  logic                  stash_valid_q, stash_valid_d;
  logic [DATA_WIDTH-1:0] stash_data_q, stash_data_d;
  logic                  drain_s;

  assign drain_s     = valid_q & rsp_ready_i;
  assign rsp_valid_o = valid_q;
  assign rsp_data_o  = data_q;
  assign req_ok_o    = (~valid_q | rsp_ready_i) & ~stash_valid_q;

  // next-state: drain (refill from stash), then capture
  always_comb begin
    valid_d       = valid_q;
    data_d        = data_q;
    stash_valid_d = stash_valid_q;
    stash_data_d  = stash_data_q;
    if (drain_s) begin
      if (stash_valid_q) begin
        valid_d       = 1'b1;
        data_d        = stash_data_q;
        stash_valid_d = 1'b0;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
    if (cap_en_i) begin
      if (!valid_d) begin
        valid_d = 1'b1;
        data_d  = cap_data_i;
      end else begin
        stash_valid_d = 1'b1;
        stash_data_d  = cap_data_i;
      end
    end else begin
      stash_valid_d = stash_valid_d;
    end
  end

  // slot state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      data_q        <= {DATA_WIDTH{1'b0}};
      stash_valid_q <= 1'b0;
      stash_data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      valid_q       <= valid_d;
      data_q        <= data_d;
      stash_valid_q <= stash_valid_d;
      stash_data_q  <= stash_data_d;
    end
  end

endmodule

// File: rtl/sram_ctrl_1rw1r.sv
// Controller for the 1RW+1R OpenRAM macro: zero-fills the array after reset,
// then maps port A (rd/wr) and port B (rd) valid/ready streams onto the macro pins.
// Define SRAM_CTRL_FWD_EN to forward colliding port A write data into port B reads
// instead of stalling port B.
module sram_ctrl_1rw1r
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_W,
  parameter int DATA_WIDTH = SRAM_DATA_W,
  parameter int NUM_WMASKS = SRAM_NWMASK
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [NUM_WMASKS-1:0] a_req_wmask,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  input  logic                  a_rsp_ready,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  output logic                  b_rsp_valid,
  input  logic                  b_rsp_ready,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,
  output logic                  init_done
);

  localparam int                    LANE_W    = DATA_WIDTH / NUM_WMASKS;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  a_pend_q, a_we_q, b_pend_q;
  logic                  run_s, a_fire_s, b_fire_s, collide_s;
  logic                  a_ok_s, b_ok_s;
  logic [DATA_WIDTH-1:0] a_cap_s, b_cap_s;

  assign init_done = init_done_q;
  assign run_s     = (state_q == ST_RUN);

  // init sequencer: one zero-write per cycle, then RUN forever
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d     = ST_INIT;
        cnt_d       = {ADDR_WIDTH{1'b0}};
        init_done_d = 1'b0;
      end
    endcase
  end

  // sequencer state and per-port in-flight markers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= {ADDR_WIDTH{1'b0}};
      init_done_q <= 1'b0;
      a_pend_q    <= 1'b0;
      a_we_q      <= 1'b0;
      b_pend_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      a_pend_q    <= a_fire_s;
      a_we_q      <= a_fire_s & a_req_we;
      b_pend_q    <= b_fire_s;
    end
  end

  assign a_req_ready = run_s & a_ok_s;
  assign a_fire_s    = a_req_valid & a_req_ready;
  assign collide_s   = a_fire_s & a_req_we & b_req_valid & (a_req_addr == b_req_addr);

`ifdef SRAM_CTRL_FWD_EN
  assign b_req_ready = run_s & b_ok_s;
`else
  // A colliding B read waits one cycle so it observes the completed write.
  assign b_req_ready = run_s & b_ok_s & ~collide_s;
`endif
  assign b_fire_s = b_req_valid & b_req_ready;

  // macro pin drive: zero-fill during INIT, request pass-through in RUN
  always_comb begin
    if (run_s) begin
      sram_csb0   = ~a_fire_s;
      sram_web0   = ~a_req_we;
      sram_wmask0 = a_req_we ? a_req_wmask : {NUM_WMASKS{1'b0}};
      sram_addr0  = a_req_addr;
      sram_din0   = a_req_wdata;
      sram_csb1   = ~b_fire_s;
      sram_addr1  = b_req_addr;
    end else begin
      sram_csb0   = 1'b0;
      sram_web0   = 1'b0;
      sram_wmask0 = {NUM_WMASKS{1'b1}};
      sram_addr0  = cnt_q;
      sram_din0   = {DATA_WIDTH{1'b0}};
      sram_csb1   = 1'b1;
      sram_addr1  = {ADDR_WIDTH{1'b0}};
    end
  end

  assign a_cap_s = a_we_q ? {DATA_WIDTH{1'b0}} : sram_dout0;

`ifdef SRAM_CTRL_FWD_EN
  logic                  fwd_q;
  logic [NUM_WMASKS-1:0] fwd_mask_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  // remember the colliding write so its lanes can override the macro read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q      <= 1'b0;
      fwd_mask_q <= {NUM_WMASKS{1'b0}};
      fwd_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      fwd_q      <= collide_s & b_fire_s;
      fwd_mask_q <= a_req_wmask;
      fwd_data_q <= a_req_wdata;
    end
  end

  for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_fwd_lane
    assign b_cap_s[g*LANE_W +: LANE_W] = (fwd_q & fwd_mask_q[g]) ?
                                         fwd_data_q[g*LANE_W +: LANE_W] :
                                         sram_dout1[g*LANE_W +: LANE_W];
  end
`else
  assign b_cap_s = sram_dout1;
`endif

  sram_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_a_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_en_i    (a_pend_q),
    .cap_data_i  (a_cap_s),
    .rsp_ready_i (a_rsp_ready),
    .rsp_valid_o (a_rsp_valid),
    .rsp_data_o  (a_rsp_rdata),
    .req_ok_o    (a_ok_s)
  );

  sram_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_b_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_en_i    (b_pend_q),
    .cap_data_i  (b_cap_s),
    .rsp_ready_i (b_rsp_ready),
    .rsp_valid_o (b_rsp_valid),
    .rsp_data_o  (b_rsp_rdata),
    .req_ok_o    (b_ok_s)
  );

endmodule
